// File: rtl/note_pkg.sv
// note_pkg: shared coordinate type, geometry constants and helpers for the
// falling-note scheduler (note_lane, note_scheduler).
package note_pkg;

    typedef logic signed [12:0] coord_t;

    localparam int COORD_W        = 13;
    localparam int LANES          = 4;
    localparam int SLOTS_PER_LANE = 4;
    localparam int NUM_SLOTS      = LANES * SLOTS_PER_LANE;
    localparam int LANE_BITS      = SLOTS_PER_LANE * COORD_W;

    localparam coord_t BOX_H    = 13'sd40;
    localparam coord_t SPAWN_Y  = -13'sd40;
    localparam coord_t HIT_Y    = 13'sd450;
    localparam coord_t HIT_WIN  = 13'sd20;
    localparam coord_t BOTTOM_Y = 13'sd480;
    localparam coord_t STEP     = 13'sd1;

    // Bound value for an empty slot: top == bottom, so nothing is drawn.
    localparam coord_t EMPTY_Y  = -BOX_H;

    // Box-top value whose centre sits exactly on the hit line.
    localparam coord_t CENTRED_TOP = HIT_Y - (BOX_H >>> 1);

    // |top + BOX_H/2 - HIT_Y| <= HIT_WIN, rewritten as a range on the box top.
    function automatic logic in_hit_window(input coord_t top);
        return (top >= CENTRED_TOP - HIT_WIN) && (top <= CENTRED_TOP + HIT_WIN);
    endfunction

endpackage

// File: rtl/note_lane.sv
// note_lane: the slot bank of one lane -- allocation, movement, retirement,
// hit selection and key-edge detection. Hit/miss events leave as
// combinational strobes; the top level registers them.
// Optional macro NOTE_SCHED_AUTOPLAY_EN: presses come from an internal
// detector that fires when a note's centre lands exactly on the hit line.
module note_lane
    import note_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_tick,
    input  logic                      i_spawn_req,
    output logic                      o_spawn_ack,
    input  logic                      i_key,
    output logic [LANE_BITS-1:0]      o_up_bound,
    output logic [LANE_BITS-1:0]      o_low_bound,
    output logic [SLOTS_PER_LANE-1:0] o_valid,
    output logic                      o_hit,
    output logic                      o_miss
);

    logic [SLOTS_PER_LANE-1:0] r_valid;
    coord_t                    r_up  [SLOTS_PER_LANE];
    coord_t                    r_low [SLOTS_PER_LANE];

    logic                      w_press;
    logic                      w_hit;
    logic                      w_free_any;
    logic                      w_cand_any;
    coord_t                    w_best_y;
    logic [SLOTS_PER_LANE-1:0] w_alloc_oh;
    logic [SLOTS_PER_LANE-1:0] w_win_oh;
    logic [SLOTS_PER_LANE-1:0] w_valid_n;
    logic [SLOTS_PER_LANE-1:0] w_retire;
    coord_t                    w_y_n [SLOTS_PER_LANE];

`ifdef NOTE_SCHED_AUTOPLAY_EN
    logic r_auto;
    logic w_auto_n;
    assign w_press = r_auto;
`else
    logic r_key_q;
    assign w_press = i_key & ~r_key_q;
`endif

    // Lowest-index free slot, judged on registered occupancy only.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        w_alloc_oh = '0;
        w_free_any = 1'b0;
        for (int i = 0; i < SLOTS_PER_LANE; i++) begin
            if (!r_valid[i] && !w_free_any) begin
                w_alloc_oh[i] = 1'b1;
                w_free_any    = 1'b1;
            end
        end
    end

    assign o_spawn_ack = i_spawn_req & w_free_any;

    // Hit candidate: deepest box in the window; strict '>' keeps the lower index on ties.
    always_comb begin
        w_win_oh   = '0;
        w_cand_any = 1'b0;
        w_best_y   = '0;
        for (int i = 0; i < SLOTS_PER_LANE; i++) begin
            // NOTE: blocking '=' here so each iteration sees the running best;
            // flops elsewhere use '<=' so all state updates on the same edge.
            if (r_valid[i] && in_hit_window(r_up[i]) &&
                (!w_cand_any || r_up[i] > w_best_y)) begin
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_cand_any  = 1'b1;
                w_best_y    = r_up[i];
            end
        end
    end

    assign w_hit  = w_press & w_cand_any;
    assign o_hit  = w_hit;
    assign o_miss = (|w_retire) | (w_press & ~w_cand_any);

    // Next slot state: hit removes, tick advances/retires, spawn fills a free slot.
    always_comb begin
        w_valid_n = r_valid;
        w_retire  = '0;
        for (int i = 0; i < SLOTS_PER_LANE; i++) begin
            w_y_n[i] = r_up[i];
        end
        for (int i = 0; i < SLOTS_PER_LANE; i++) begin
            if (w_hit && w_win_oh[i]) begin
                w_valid_n[i] = 1'b0;
            end else if (r_valid[i] && i_tick) begin
                w_y_n[i] = r_up[i] + STEP;
                if (w_y_n[i] >= BOTTOM_Y) begin
                    w_valid_n[i] = 1'b0;
                    w_retire[i]  = 1'b1;
                end
            end
            if (o_spawn_ack && w_alloc_oh[i]) begin
                w_valid_n[i] = 1'b1;
                w_y_n[i]     = SPAWN_Y;
            end
        end
    end

    // Slot registers; the top bound doubles as the stored y position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            // NOTE: this small bank drives display outputs directly, so every
            // entry is reset; a large RAM-style store would not be.
            for (int i = 0; i < SLOTS_PER_LANE; i++) begin
                r_up[i]  <= EMPTY_Y;
                r_low[i] <= EMPTY_Y;
            end
        end else begin
            r_valid <= w_valid_n;
            for (int i = 0; i < SLOTS_PER_LANE; i++) begin
                if (w_valid_n[i]) begin
                    r_up[i]  <= w_y_n[i];
                    r_low[i] <= w_y_n[i] + BOX_H;
                end else begin
                    r_up[i]  <= EMPTY_Y;
                    r_low[i] <= EMPTY_Y;
                end
            end
        end
    end

`ifdef NOTE_SCHED_AUTOPLAY_EN
    // Autoplay press: some slot that moved this tick now has its centre on the hit line.
    always_comb begin
        w_auto_n = 1'b0;
        for (int i = 0; i < SLOTS_PER_LANE; i++) begin
            if (i_tick && r_valid[i] && w_valid_n[i] && (w_y_n[i] == CENTRED_TOP)) begin
                w_auto_n = 1'b1;
            end
        end
    end

    // Autoplay press register, judged on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_auto <= 1'b0;
        else        r_auto <= w_auto_n;
    end
`else
    // Previous key level for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_key_q <= 1'b0;
        else        r_key_q <= i_key;
    end
`endif

    for (genvar gi = 0; gi < SLOTS_PER_LANE; gi++) begin : g_flat
        assign o_up_bound [gi*COORD_W +: COORD_W] = r_up[gi];
        assign o_low_bound[gi*COORD_W +: COORD_W] = r_low[gi];
    end

    assign o_valid = r_valid;

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: falling-note sequencer for the rhythm-game display.
// One note_lane per key; this level registers the hit/miss pulses and
// keeps the saturating score and combo for the HUD.
// Optional macro NOTE_SCHED_AUTOPLAY_EN (handled inside note_lane): the key
// input is ignored and presses are generated at the hit line.
module note_scheduler
    import note_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic [LANES-1:0]               spawn_req,
    output logic [LANES-1:0]               spawn_ack,
    input  logic [LANES-1:0]               key,
    output logic [NUM_SLOTS*COORD_W-1:0]   upBound,
    output logic [NUM_SLOTS*COORD_W-1:0]   lowBound,
    output logic [NUM_SLOTS-1:0]           slot_valid,
    output logic [LANES-1:0]               hit_pulse,
    output logic [LANES-1:0]               miss_pulse,
    output logic [15:0]                    score,
    output logic [7:0]                     combo
);

    localparam int CNT_W = $clog2(LANES + 1);

    logic [LANES-1:0] w_hit;
    logic [LANES-1:0] w_miss;
    logic [CNT_W-1:0] w_hit_cnt;
    logic [16:0]      w_score_sum;
    logic [8:0]       w_combo_sum;

    logic [LANES-1:0] r_hit;
    logic [LANES-1:0] r_miss;
    logic [15:0]      r_score;
    logic [7:0]       r_combo;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        note_lane u_lane (
            .clk         (clk),
            .reset       (reset),
            .i_tick      (tick),
            .i_spawn_req (spawn_req[l]),
            .o_spawn_ack (spawn_ack[l]),
            .i_key       (key[l]),
            .o_up_bound  (upBound [l*LANE_BITS +: LANE_BITS]),
            .o_low_bound (lowBound[l*LANE_BITS +: LANE_BITS]),
            .o_valid     (slot_valid[l*SLOTS_PER_LANE +: SLOTS_PER_LANE]),
            .o_hit       (w_hit[l]),
            .o_miss      (w_miss[l])
        );
    end

    // Popcount of lanes hit this cycle and the unsaturated new totals.
    always_comb begin
        w_hit_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            w_hit_cnt = w_hit_cnt + CNT_W'(w_hit[l]);
        end
        w_score_sum = {1'b0, r_score} + 17'(w_hit_cnt);
        w_combo_sum = {1'b0, r_combo} + 9'(w_hit_cnt);
    end

    // Registered pulses, saturating score, combo cleared by any miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit   <= '0;
            r_miss  <= '0;
            r_score <= '0;
            r_combo <= '0;
        end else begin
            r_hit   <= w_hit;
            r_miss  <= w_miss;
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            if (|w_miss)             r_combo <= '0;
            else if (w_combo_sum[8]) r_combo <= 8'hFF;
            else                     r_combo <= w_combo_sum[7:0];
        end
    end

    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;
    assign score      = r_score;
    assign combo      = r_combo;

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed scenarios plus randomized play for
// note_scheduler, checked against a behavioural model of the game rules.
module tb_note_scheduler;

    localparam int LN    = 4;
    localparam int SP    = 4;
    localparam int NS    = LN * SP;
    localparam int W     = 13;
    localparam int BOX   = 40;
    localparam int SPAWN = -40;
    localparam int HITY  = 450;
    localparam int WIN   = 20;
    localparam int BOT   = 480;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic [LN-1:0]     spawn_req;
    logic [LN-1:0]     spawn_ack;
    logic [LN-1:0]     key;
    logic [NS*W-1:0]   upBound;
    logic [NS*W-1:0]   lowBound;
    logic [NS-1:0]     slot_valid;
    logic [LN-1:0]     hit_pulse;
    logic [LN-1:0]     miss_pulse;
    logic [15:0]       score;
    logic [7:0]        combo;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid [NS];
    int          m_y     [NS];
    bit [LN-1:0] m_key_q;
    bit [LN-1:0] m_hit;
    bit [LN-1:0] m_miss;
    int          m_score;
    int          m_combo;

    note_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .spawn_req  (spawn_req),
        .spawn_ack  (spawn_ack),
        .key        (key),
        .upBound    (upBound),
        .lowBound   (lowBound),
        .slot_valid (slot_valid),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .combo      (combo)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) begin
            m_valid[s] = 1'b0;
            m_y[s]     = SPAWN;
        end
        m_key_q = '0;
        m_hit   = '0;
        m_miss  = '0;
        m_score = 0;
        m_combo = 0;
    endfunction

    function automatic logic [LN-1:0] model_ack();
        logic [LN-1:0] a;
        a = '0;
        for (int l = 0; l < LN; l++)
            for (int i = 0; i < SP; i++)
                if (spawn_req[l] && !m_valid[l*SP+i]) a[l] = 1'b1;
        return a;
    endfunction

    // One clock of game rules, applied to the inputs present at the edge.
    function automatic void model_update();
        int  best, fr, s, nhits;
        bit  press, hit, retired, anymiss;
        nhits   = 0;
        anymiss = 0;
        for (int l = 0; l < LN; l++) begin
            press   = key[l] && !m_key_q[l];
            best    = -1;
            fr      = -1;
            retired = 0;
            for (int i = 0; i < SP; i++) begin
                s = l*SP + i;
                if (m_valid[s] && iabs(m_y[s] + BOX/2 - HITY) <= WIN &&
                    (best < 0 || m_y[s] > m_y[best])) best = s;
                if (!m_valid[s] && fr < 0) fr = s;
            end
            hit = press && (best >= 0);
            for (int i = 0; i < SP; i++) begin
                s = l*SP + i;
                if (hit && s == best) m_valid[s] = 0;
                else if (m_valid[s] && tick) begin
                    if (m_y[s] + 1 >= BOT) begin
                        m_valid[s] = 0;
                        retired    = 1;
                    end else m_y[s] = m_y[s] + 1;
                end
            end
            if (spawn_req[l] && fr >= 0) begin
                m_valid[fr] = 1;
                m_y[fr]     = SPAWN;
            end
            m_hit[l]  = hit;
            m_miss[l] = retired || (press && best < 0);
            if (hit)       nhits++;
            if (m_miss[l]) anymiss = 1;
        end
        m_key_q = key;
        m_score = (m_score + nhits > 65535) ? 65535 : m_score + nhits;
        m_combo = anymiss ? 0 : ((m_combo + nhits > 255) ? 255 : m_combo + nhits);
    endfunction

    function automatic logic [NS*W-1:0] exp_up();
        logic [NS*W-1:0] v;
        for (int s = 0; s < NS; s++) v[s*W +: W] = m_valid[s] ? W'(m_y[s]) : W'(-BOX);
        return v;
    endfunction

    function automatic logic [NS*W-1:0] exp_low();
        logic [NS*W-1:0] v;
        for (int s = 0; s < NS; s++) v[s*W +: W] = m_valid[s] ? W'(m_y[s] + BOX) : W'(-BOX);
        return v;
    endfunction

    function automatic logic [NS-1:0] exp_valid();
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_valid[s];
        return v;
    endfunction

    function automatic logic [NS*W-1:0] all_empty();
        logic [NS*W-1:0] v;
        for (int s = 0; s < NS; s++) v[s*W +: W] = W'(-BOX);
        return v;
    endfunction

    function automatic int dut_up(input int s);
        logic signed [W-1:0] v;
        v = upBound[s*W +: W];
        return int'(v);
    endfunction

    function automatic int dut_low(input int s);
        logic signed [W-1:0] v;
        v = lowBound[s*W +: W];
        return int'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick_n(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        tick      = 1'b0;
        spawn_req = '0;
        key       = '0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        tick = 1'b0; spawn_req = '0; key = '0; reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        checks++; if (slot_valid !== '0) begin errors++; $display("FAIL reset_valid: got %h expected 0", slot_valid); end
        checks++; if (upBound !== all_empty()) begin errors++; $display("FAIL reset_up: got %h", upBound); end
        checks++; if (lowBound !== all_empty()) begin errors++; $display("FAIL reset_low: got %h", lowBound); end
        checks++; if (score !== 16'd0 || combo !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d/%0d expected 0/0", score, combo); end
        checks++; if (hit_pulse !== '0 || miss_pulse !== '0) begin errors++; $display("FAIL reset_pulses: got %b/%b expected 0/0", hit_pulse, miss_pulse); end
    endtask

    task automatic test_spawn();
        spawn_req = 4'b0001;
        #1;
        checks++; if (spawn_ack !== 4'b0001) begin errors++; $display("FAIL spawn_ack: got %b expected 0001", spawn_ack); end
        step();
        spawn_req = '0;
        checks++; if (slot_valid[0] !== 1'b1 || dut_up(0) != -40 || dut_low(0) != 0) begin
            errors++; $display("FAIL spawn_slot0: got v=%b %0d/%0d expected 1 -40/0", slot_valid[0], dut_up(0), dut_low(0)); end
        tick_n(1);
        checks++; if (dut_up(0) != -39 || dut_low(0) != 1) begin
            errors++; $display("FAIL spawn_move: got %0d/%0d expected -39/1", dut_up(0), dut_low(0)); end
    endtask

    task automatic test_spawn_full();
        logic [4:0] acks;
        do_reset();
        spawn_req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            acks[k] = spawn_ack[2];
            step();
        end
        spawn_req = '0;
        checks++; if (acks !== 5'b01111) begin errors++; $display("FAIL full_ack_seq: got %b expected 01111", acks); end
        checks++; if (slot_valid !== 16'h0F00) begin errors++; $display("FAIL full_valid: got %h expected 0f00", slot_valid); end
    endtask

    task automatic test_hit_hold();
        int n;
        do_reset();
        spawn_req = 4'b0010; step(); spawn_req = '0;
        tick_n(470);
        checks++; if (dut_up(4) != 430 || dut_low(4) != 470) begin
            errors++; $display("FAIL hit_position: got %0d/%0d expected 430/470", dut_up(4), dut_low(4)); end
        key[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (hit_pulse[1]) n++;
        end
        key[1] = 1'b0;
        checks++; if (n != 1) begin errors++; $display("FAIL hit_count: got %0d expected 1", n); end
        checks++; if (slot_valid[4] !== 1'b0) begin errors++; $display("FAIL hit_invalid: got %b expected 0", slot_valid[4]); end
        checks++; if (score !== 16'd1 || combo !== 8'd1) begin errors++; $display("FAIL hit_score: got %0d/%0d expected 1/1", score, combo); end
    endtask

    task automatic test_retire_ghost();
        do_reset();
        spawn_req = 4'b1001; step(); spawn_req = '0;
        tick_n(470);
        key[0] = 1'b1; step(); key[0] = 1'b0;
        checks++; if (score !== 16'd1 || combo !== 8'd1) begin errors++; $display("FAIL pre_retire_score: got %0d/%0d expected 1/1", score, combo); end
        step();
        tick_n(49);
        checks++; if (slot_valid[12] !== 1'b1 || dut_up(12) != 479) begin
            errors++; $display("FAIL pre_retire_pos: got v=%b %0d expected 1 479", slot_valid[12], dut_up(12)); end
        tick_n(1);
        checks++; if (slot_valid[12] !== 1'b0 || miss_pulse !== 4'b1000) begin
            errors++; $display("FAIL retire: got v=%b miss=%b expected 0 1000", slot_valid[12], miss_pulse); end
        checks++; if (combo !== 8'd0 || score !== 16'd1) begin errors++; $display("FAIL retire_score: got %0d/%0d expected 1/0", score, combo); end
        key[0] = 1'b1; step(); key[0] = 1'b0;
        checks++; if (miss_pulse !== 4'b0001 || hit_pulse !== 4'b0000) begin
            errors++; $display("FAIL ghost: got miss=%b hit=%b expected 0001 0000", miss_pulse, hit_pulse); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        spawn_req = 4'b1011; step(); spawn_req = '0;
        tick_n(470);
        key = 4'b1001; tick = 1'b1; step(); key = '0; tick = 1'b0;
        checks++; if (hit_pulse !== 4'b1001 || miss_pulse !== 4'b0000) begin
            errors++; $display("FAIL simul_pulses: got hit=%b miss=%b expected 1001 0000", hit_pulse, miss_pulse); end
        checks++; if (score !== 16'd2 || combo !== 8'd2) begin errors++; $display("FAIL simul_score: got %0d/%0d expected 2/2", score, combo); end
        checks++; if (slot_valid[0] !== 1'b0 || slot_valid[12] !== 1'b0 || dut_up(0) != -40) begin
            errors++; $display("FAIL simul_hit_slots: got v0=%b v12=%b up0=%0d expected 0 0 -40", slot_valid[0], slot_valid[12], dut_up(0)); end
        checks++; if (slot_valid[4] !== 1'b1 || dut_up(4) != 431) begin
            errors++; $display("FAIL simul_lane1: got v=%b %0d expected 1 431", slot_valid[4], dut_up(4)); end
    endtask

    task automatic test_window();
        do_reset();
        spawn_req = 4'b0100; step(); spawn_req = '0;
        tick_n(449);
        key[2] = 1'b1; step(); key[2] = 1'b0;
        checks++; if (miss_pulse[2] !== 1'b1 || slot_valid[8] !== 1'b1) begin
            errors++; $display("FAIL window_low_out: got miss=%b v=%b expected 1 1", miss_pulse[2], slot_valid[8]); end
        tick_n(1);
        key[2] = 1'b1; step(); key[2] = 1'b0;
        checks++; if (hit_pulse[2] !== 1'b1 || slot_valid[8] !== 1'b0) begin
            errors++; $display("FAIL window_low_in: got hit=%b v=%b expected 1 0", hit_pulse[2], slot_valid[8]); end
        spawn_req = 4'b0010; step(); step(); spawn_req = '0;
        tick_n(490);
        key[1] = 1'b1; step(); key[1] = 1'b0;
        checks++; if (hit_pulse[1] !== 1'b1 || slot_valid[5:4] !== 2'b10) begin
            errors++; $display("FAIL window_high_tie: got hit=%b v=%b expected 1 10", hit_pulse[1], slot_valid[5:4]); end
        tick_n(1);
        key[1] = 1'b1; step(); key[1] = 1'b0;
        checks++; if (miss_pulse[1] !== 1'b1 || slot_valid[5] !== 1'b1 || dut_up(5) != 451) begin
            errors++; $display("FAIL window_high_out: got miss=%b v=%b up=%0d expected 1 1 451", miss_pulse[1], slot_valid[5], dut_up(5)); end
    endtask

    task automatic test_full_free_next();
        do_reset();
        spawn_req = 4'b0001; repeat (4) step(); spawn_req = '0;
        tick_n(470);
        spawn_req = 4'b0001; key[0] = 1'b1;
        #1;
        checks++; if (spawn_ack[0] !== 1'b0) begin errors++; $display("FAIL full_lane_ack: got %b expected 0", spawn_ack[0]); end
        step();
        checks++; if (hit_pulse[0] !== 1'b1 || slot_valid[3:0] !== 4'b1110) begin
            errors++; $display("FAIL full_tie_hit: got hit=%b v=%b expected 1 1110", hit_pulse[0], slot_valid[3:0]); end
        checks++; if (spawn_ack[0] !== 1'b1) begin errors++; $display("FAIL freed_ack: got %b expected 1", spawn_ack[0]); end
        step();
        spawn_req = '0; key[0] = 1'b0;
        checks++; if (slot_valid[3:0] !== 4'hF || dut_up(0) != -40 || dut_up(1) != 430) begin
            errors++; $display("FAIL freed_spawn: got v=%b up0=%0d up1=%0d expected f -40 430", slot_valid[3:0], dut_up(0), dut_up(1)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000 && errors < 40; c++) begin
            tick      = ($urandom_range(3) != 0);
            spawn_req = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            for (int l = 0; l < LN; l++)
                if ($urandom_range(11) == 0) key[l] = ~key[l];
            #1;
            checks++; if (spawn_ack !== model_ack()) begin
                errors++; $display("FAIL rand_ack c=%0d: got %b expected %b", c, spawn_ack, model_ack()); end
            step();
            checks++; if (slot_valid !== exp_valid()) begin
                errors++; $display("FAIL rand_valid c=%0d: got %h expected %h", c, slot_valid, exp_valid()); end
            checks++; if (upBound !== exp_up() || lowBound !== exp_low()) begin
                errors++; $display("FAIL rand_bounds c=%0d: got up %h expected %h", c, upBound, exp_up()); end
            checks++; if (hit_pulse !== m_hit || miss_pulse !== m_miss) begin
                errors++; $display("FAIL rand_pulses c=%0d: got %b/%b expected %b/%b", c, hit_pulse, miss_pulse, m_hit, m_miss); end
            checks++; if (score !== 16'(m_score) || combo !== 8'(m_combo)) begin
                errors++; $display("FAIL rand_score c=%0d: got %0d/%0d expected %0d/%0d", c, score, combo, m_score, m_combo); end
        end
        tick = 1'b0; spawn_req = '0; key = '0;
    endtask

    task automatic test_reset_mid();
        spawn_req = 4'b1111; step(); spawn_req = '0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (slot_valid !== '0 || upBound !== all_empty() || lowBound !== all_empty()) begin
            errors++; $display("FAIL midreset_slots: got v=%h", slot_valid); end
        checks++; if (score !== 16'd0 || combo !== 8'd0 || hit_pulse !== '0 || miss_pulse !== '0) begin
            errors++; $display("FAIL midreset_hud: got %0d/%0d expected 0/0", score, combo); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_spawn_full();
        test_hit_hold();
        test_retire_ghost();
        test_simultaneous();
        test_window();
        test_full_free_next();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
